// File: rtl/matrix_stripe_packer.sv
// matrix_stripe_packer: regroups panel pixel pairs into colour/panel byte regions and writes 384-bit words
module matrix_stripe_packer #(
    parameter int BANK_COUNT         = 6,
    parameter int BLOCK_COUNT        = 2,
    parameter int BLOCK_DATA_WIDTH_A = 32,
    parameter int BYTES_PER_BLOCK    = 2250,
    parameter int SWAP_CYCLES        = 6
) (
    input  logic                                                    clk_a,
    input  logic                                                    rst_n,
    input  logic                                                    I_pixel_valid,
    output logic                                                    O_pixel_ready,
    input  logic [BLOCK_COUNT*24-1:0]                               I_pixel_rgb,
    input  logic                                                    I_frame_end,
    output logic [$clog2(BYTES_PER_BLOCK*8/BLOCK_DATA_WIDTH_A)-1:0] O_write_address,
    output logic [BANK_COUNT*BLOCK_COUNT*BLOCK_DATA_WIDTH_A-1:0]    O_data_flat,
    output logic                                                    O_clk_data_in,
    output logic                                                    O_swap_trigger,
    output logic                                                    O_overflow
);
    localparam int PANEL_COUNT = BLOCK_COUNT;
    localparam int DW          = BANK_COUNT * BLOCK_COUNT * BLOCK_DATA_WIDTH_A;
    localparam int GROUP_PIXELS = DW / 8 / (3 * PANEL_COUNT);
    localparam int ADDR_NUM    = BYTES_PER_BLOCK * 8 / BLOCK_DATA_WIDTH_A;
    localparam int AW          = $clog2(ADDR_NUM);
    localparam int IW          = $clog2(GROUP_PIXELS);
    localparam int SW          = $clog2(SWAP_CYCLES + 1);

    typedef enum logic [2:0] {COLLECT, SETUP, PULSE, HOLD, SWAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   staging_q, staging_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   swap_cnt_q, swap_cnt_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            flush_q, flush_d;
    logic            pend_q, pend_d;
    logic            accept;
    logic            complete;
    logic            has_data;
    logic            last_addr;

    assign O_pixel_ready   = state_q == COLLECT;
    assign O_clk_data_in   = state_q == PULSE;
    assign O_swap_trigger  = state_q == SWAP;
    assign O_write_address = addr_q;
    assign O_data_flat     = data_q;
    assign O_overflow      = ovf_q;

    // next-state, staging byte placement and write/swap sequencing
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        staging_d  = staging_q;
        data_d     = data_q;
        addr_d     = addr_q;
        swap_cnt_d = swap_cnt_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        flush_d    = flush_q;
        pend_d     = pend_q;
        accept     = I_pixel_valid && state_q == COLLECT;
        complete   = accept && idx_q == IW'(GROUP_PIXELS - 1);
        has_data   = accept || idx_q != '0;
        last_addr  = addr_q == AW'(ADDR_NUM - 1);
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int p = 0; p < PANEL_COUNT; p++)
                        for (int c = 0; c < 3; c++)
                            staging_d[((c * PANEL_COUNT + p) * GROUP_PIXELS + int'(idx_q)) * 8 +: 8] =
                                I_pixel_rgb[p * 24 + (2 - c) * 8 +: 8];
                    idx_d = idx_q + 1'b1;
                end
                if (complete || (I_frame_end && has_data)) begin
                    state_d   = SETUP;
                    data_d    = staging_d;
                    staging_d = '0;
                    idx_d     = '0;
                    flush_d   = I_frame_end;
                end else if (I_frame_end) begin
                    state_d    = SWAP;
                    swap_cnt_d = '0;
                end
            end
            SETUP: begin
                pend_d = pend_q | I_frame_end;
                if (full_q) begin
                    ovf_d      = 1'b1;
                    state_d    = (flush_q || pend_q || I_frame_end) ? SWAP : COLLECT;
                    flush_d    = 1'b0;
                    pend_d     = 1'b0;
                    swap_cnt_d = '0;
                end else begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                pend_d  = pend_q | I_frame_end;
                state_d = HOLD;
            end
            HOLD: begin
                addr_d     = last_addr ? addr_q : addr_q + 1'b1;
                full_d     = full_q | last_addr;
                state_d    = (flush_q || pend_q || I_frame_end) ? SWAP : COLLECT;
                flush_d    = 1'b0;
                pend_d     = 1'b0;
                swap_cnt_d = '0;
            end
            SWAP: begin
                if (swap_cnt_q == SW'(SWAP_CYCLES - 1)) begin
                    state_d = COLLECT;
                    addr_d  = '0;
                    full_d  = 1'b0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    swap_cnt_d = swap_cnt_q + 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_a) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            staging_q  <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            swap_cnt_q <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            flush_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            staging_q  <= staging_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            swap_cnt_q <= swap_cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            flush_q    <= flush_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: tb/tb_matrix_stripe_packer.sv
// tb_matrix_stripe_packer: directed checks of packing, commit timing, flush, swap and overflow
module tb_matrix_stripe_packer;
    logic         clk_a = 1'b0;
    logic         rst_n;
    logic         I_pixel_valid;
    logic         O_pixel_ready;
    logic [47:0]  I_pixel_rgb;
    logic         I_frame_end;
    logic [9:0]   O_write_address;
    logic [383:0] O_data_flat;
    logic         O_clk_data_in;
    logic         O_swap_trigger;
    logic         O_overflow;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_strobe = 0;
    int           n_swaps = 0;
    int           swap_len = 0;
    int           last_swap_len = 0;
    logic         was_strobe = 1'b0;
    logic [383:0] prev_data = '0;
    logic [383:0] strobe_data = '0;
    logic [9:0]   strobe_addr = '0;
    logic [9:0]   s_addr[$];

    matrix_stripe_packer dut (
        .clk_a(clk_a),
        .rst_n(rst_n),
        .I_pixel_valid(I_pixel_valid),
        .O_pixel_ready(O_pixel_ready),
        .I_pixel_rgb(I_pixel_rgb),
        .I_frame_end(I_frame_end),
        .O_write_address(O_write_address),
        .O_data_flat(O_data_flat),
        .O_clk_data_in(O_clk_data_in),
        .O_swap_trigger(O_swap_trigger),
        .O_overflow(O_overflow)
    );

    // free-running pixel clock
    always #5 clk_a = ~clk_a;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // strobe/swap monitor: records write addresses, checks data/address stability, measures swap length
    always @(negedge clk_a) begin
        if (was_strobe) begin
            chk("hold_data", O_data_flat, strobe_data);
            chk("hold_addr", 384'(O_write_address), 384'(strobe_addr));
        end
        was_strobe = O_clk_data_in === 1'b1;
        if (O_clk_data_in === 1'b1) begin
            chk("setup_data", O_data_flat, prev_data);
            s_addr.push_back(O_write_address);
            strobe_data = O_data_flat;
            strobe_addr = O_write_address;
            n_strobe++;
        end
        if (O_swap_trigger === 1'b1) swap_len++;
        else if (swap_len != 0) begin
            last_swap_len = swap_len;
            swap_len = 0;
            n_swaps++;
        end
        prev_data = O_data_flat;
    end

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 30 && O_pixel_ready !== 1'b1; k++) tick();
        if (k == 30) chk("ready_timeout", 384'(O_pixel_ready), 384'(1));
    endtask

    task automatic beat(input int i, input bit fe);
        wait_ready();
        I_pixel_valid = 1'b1;
        I_frame_end   = fe;
        I_pixel_rgb   = {8'h12, 8'h22, 8'(8'h32 + i), 8'h11, 8'h21, 8'(8'h31 + i)};
        tick();
        I_pixel_valid = 1'b0;
        I_frame_end   = 1'b0;
    endtask

    task automatic group(input bit fe_last);
        for (int i = 0; i < 8; i++) beat(i, fe_last && i == 7);
    endtask

    task automatic end_pulse();
        wait_ready();
        I_frame_end = 1'b1;
        tick();
        I_frame_end = 1'b0;
    endtask

    task automatic wait_swaps(input int target);
        for (int k = 0; k < 100 && n_swaps < target; k++) tick();
        chk("swap_seen", 384'(n_swaps >= target), 384'(1));
    endtask

    function automatic logic [383:0] pat_word(input int n);
        logic [383:0] w = '0;
        for (int i = 0; i < n; i++) begin
            w[(0 + i) * 8 +: 8]  = 8'h11;
            w[(8 + i) * 8 +: 8]  = 8'h12;
            w[(16 + i) * 8 +: 8] = 8'h21;
            w[(24 + i) * 8 +: 8] = 8'h22;
            w[(32 + i) * 8 +: 8] = 8'(8'h31 + i);
            w[(40 + i) * 8 +: 8] = 8'(8'h32 + i);
        end
        return w;
    endfunction

    initial begin
        int s0, w0, b0;
        logic [383:0] d;
        rst_n = 1'b0;
        I_pixel_valid = 1'b0;
        I_frame_end = 1'b0;
        I_pixel_rgb = '0;
        tick();
        tick();
        chk("rst_addr", 384'(O_write_address), 384'(0));
        chk("rst_data", O_data_flat, 384'(0));
        chk("rst_strobe", 384'(O_clk_data_in), 384'(0));
        chk("rst_swap", 384'(O_swap_trigger), 384'(0));
        chk("rst_ovf", 384'(O_overflow), 384'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 384'(O_pixel_ready), 384'(1));

        // packing and commit timing
        s0 = n_strobe;
        w0 = n_swaps;
        group(1'b0);
        d = O_data_flat;
        chk("setup_ready", 384'(O_pixel_ready), 384'(0));
        chk("setup_strobe", 384'(O_clk_data_in), 384'(0));
        chk("pack_word", d, pat_word(8));
        chk("byte0", 384'(d[0 +: 8]), 384'(8'h11));
        chk("byte8", 384'(d[64 +: 8]), 384'(8'h12));
        chk("byte16", 384'(d[128 +: 8]), 384'(8'h21));
        chk("byte40", 384'(d[320 +: 8]), 384'(8'h32));
        chk("byte47", 384'(d[376 +: 8]), 384'(8'h39));
        tick();
        chk("pulse_strobe", 384'(O_clk_data_in), 384'(1));
        chk("pulse_ready", 384'(O_pixel_ready), 384'(0));
        chk("pulse_addr", 384'(O_write_address), 384'(0));
        tick();
        chk("hold_strobe", 384'(O_clk_data_in), 384'(0));
        chk("hold_ready", 384'(O_pixel_ready), 384'(0));
        tick();
        chk("back_ready", 384'(O_pixel_ready), 384'(1));
        chk("addr_inc", 384'(O_write_address), 384'(1));
        end_pulse();
        wait_swaps(w0 + 1);
        chk("swap_len1", 384'(last_swap_len), 384'(6));
        chk("swap_addr0", 384'(O_write_address), 384'(0));
        chk("strobes1", 384'(n_strobe - s0), 384'(1));

        // six groups then frame end
        s0 = n_strobe;
        w0 = n_swaps;
        b0 = s_addr.size();
        for (int g = 0; g < 6; g++) group(1'b0);
        end_pulse();
        wait_swaps(w0 + 1);
        chk("six_strobes", 384'(n_strobe - s0), 384'(6));
        for (int k = 0; k < 6; k++)
            if (b0 + k < s_addr.size()) chk("six_addr", 384'(s_addr[b0 + k]), 384'(k));
        chk("swap_len6", 384'(last_swap_len), 384'(6));
        chk("six_addr0", 384'(O_write_address), 384'(0));

        // partial flush of 3 beats
        s0 = n_strobe;
        w0 = n_swaps;
        for (int i = 0; i < 3; i++) beat(i, 1'b0);
        end_pulse();
        chk("flush_word", O_data_flat, pat_word(3));
        wait_swaps(w0 + 1);
        chk("flush_strobes", 384'(n_strobe - s0), 384'(1));
        chk("flush_data", strobe_data, pat_word(3));

        // frame end on the 8th beat
        s0 = n_strobe;
        w0 = n_swaps;
        group(1'b1);
        wait_swaps(w0 + 1);
        for (int k = 0; k < 10; k++) tick();
        chk("simul_strobes", 384'(n_strobe - s0), 384'(1));
        chk("simul_swaps", 384'(n_swaps - w0), 384'(1));

        // frame end during PULSE
        s0 = n_strobe;
        w0 = n_swaps;
        group(1'b0);
        tick();
        chk("pend_in_pulse", 384'(O_clk_data_in), 384'(1));
        I_frame_end = 1'b1;
        tick();
        I_frame_end = 1'b0;
        wait_swaps(w0 + 1);
        for (int k = 0; k < 10; k++) tick();
        chk("pend_strobes", 384'(n_strobe - s0), 384'(1));
        chk("pend_swaps", 384'(n_swaps - w0), 384'(1));

        // overflow: 563 groups in one frame
        s0 = n_strobe;
        w0 = n_swaps;
        for (int g = 0; g < 562; g++) group(1'b0);
        tick();
        tick();
        tick();
        chk("ovf_strobes", 384'(n_strobe - s0), 384'(562));
        chk("ovf_last_addr", 384'(s_addr[s_addr.size() - 1]), 384'(561));
        chk("ovf_sat_addr", 384'(O_write_address), 384'(561));
        chk("ovf_before", 384'(O_overflow), 384'(0));
        group(1'b0);
        tick();
        tick();
        tick();
        chk("ovf_set", 384'(O_overflow), 384'(1));
        chk("ovf_no_strobe", 384'(n_strobe - s0), 384'(562));
        chk("ovf_addr_hold", 384'(O_write_address), 384'(561));
        end_pulse();
        wait_swaps(w0 + 1);
        chk("ovf_cleared", 384'(O_overflow), 384'(0));
        chk("ovf_addr0", 384'(O_write_address), 384'(0));

        // reset mid-swap aborts it
        end_pulse();
        tick();
        chk("mid_swap", 384'(O_swap_trigger), 384'(1));
        rst_n = 1'b0;
        tick();
        chk("abort_swap", 384'(O_swap_trigger), 384'(0));
        rst_n = 1'b1;
        tick();
        chk("abort_ready", 384'(O_pixel_ready), 384'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
